pspin_ctrl_csr: RTL and testbench

PSPIN_CTRL_CSR -- requirements
Module: pspin_ctrl_csr

---
 rtl/pspin_ctrl_csr.sv | 227 ++++++++++++++++++++++
 tb/tb_pspin_ctrl_csr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pspin_ctrl_csr.sv
// AXI-Lite control/status block for the PsPIN cluster: fetch enable, aux reset,
// EOC sticky interrupt, status readback, MPQ full flags and stdout FIFO pops.
module pspin_ctrl_csr #(
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_CLUSTERS = 2,
  parameter int NUM_MPQ      = 256,
  parameter int NUM_STDOUT   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [NUM_CLUSTERS-1:0]   cl_fetch_en_o,
  output logic                      aux_rst_o,
  output logic                      irq_o,
  input  logic [NUM_CLUSTERS-1:0]   cl_eoc_i,
  input  logic [NUM_CLUSTERS-1:0]   cl_busy_i,
  input  logic [NUM_MPQ-1:0]        mpq_full_i,
  output logic [NUM_STDOUT-1:0]     stdout_rd_en,
  input  logic [32*NUM_STDOUT-1:0]  stdout_dout,
  input  logic [NUM_STDOUT-1:0]     stdout_data_valid
);
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [31:0] MPQ_END = 32'h200 + 32'(NUM_MPQ / 8);
  localparam logic [31:0] STD_END = 32'h1000 + 32'(4 * NUM_STDOUT);

  function automatic logic [31:0] word_off(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) & ~32'h3;
  endfunction

  typedef enum logic       {R_IDLE, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

  rstate_t rstate;
  wstate_t wstate;

  logic [NUM_CLUSTERS-1:0] fetch_en, eoc_sticky, irq_mask, eoc_q, eoc_prev, busy_q;
  logic                    aux_rst;
  logic [NUM_MPQ-1:0]      mpq_q;

  // ---------------- read decode ----------------
  logic [31:0]   roff, rd_data;
  logic [1:0]    rd_resp;
  logic [7:0]    rd_pop8, dv_pad;
  logic [1023:0] mpq_pad;
  logic [255:0]  dout_pad;
  logic [2:0]    sch;

  assign roff     = word_off(s_axil_araddr);
  assign mpq_pad  = 1024'(mpq_q);
  assign dout_pad = 256'(stdout_dout);
  assign dv_pad   = 8'(stdout_data_valid);
  assign sch      = roff[4:2];

  always_comb begin
    rd_data = 32'hFFFF_FFFF;
    rd_resp = DECERR;
    rd_pop8 = '0;
    case (roff)
      32'h000: begin rd_data = 32'(fetch_en);   rd_resp = OKAY; end
      32'h004: begin rd_data = {31'd0, aux_rst}; rd_resp = OKAY; end
      32'h008: begin rd_data = 32'(eoc_sticky); rd_resp = OKAY; end
      32'h00C: begin rd_data = 32'(irq_mask);   rd_resp = OKAY; end
      32'h100: begin rd_data = 32'(eoc_q);      rd_resp = OKAY; end
      32'h104: begin rd_data = 32'(busy_q);     rd_resp = OKAY; end
      32'h108: begin rd_data = 32'(dv_pad);     rd_resp = OKAY; end
      default: begin
        if (roff >= 32'h200 && roff < MPQ_END) begin
          rd_data = mpq_pad[{roff[6:2], 5'd0} +: 32];
          rd_resp = OKAY;
        end else if (roff >= 32'h1000 && roff < STD_END) begin
          // an empty channel reads as all-ones but is still a legal access
          rd_resp = OKAY;
          if (dv_pad[sch]) begin
            rd_data      = dout_pad[{sch, 5'd0} +: 32];
            rd_pop8[sch] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate         <= R_IDLE;
      s_axil_arready <= 1'b1;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= OKAY;
      stdout_rd_en   <= '0;
    end else begin
      stdout_rd_en <= '0;
      case (rstate)
        R_IDLE: if (s_axil_arvalid) begin
          rstate         <= R_RESP;
          s_axil_arready <= 1'b0;
          s_axil_rvalid  <= 1'b1;
          s_axil_rdata   <= rd_data;
          s_axil_rresp   <= rd_resp;
          stdout_rd_en   <= rd_pop8[NUM_STDOUT-1:0];
        end
        R_RESP: if (s_axil_rready) begin
          rstate         <= R_IDLE;
          s_axil_arready <= 1'b1;
          s_axil_rvalid  <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [31:0]           wd_q, w_data, woff, bm;
  logic [3:0]            ws_q, w_strb;
  logic [1:0]            wr_resp;
  logic                  w_fire;

  assign woff   = word_off((wstate == W_DATA) ? aw_q : s_axil_awaddr);
  assign w_data = (wstate == W_ADDR) ? wd_q : s_axil_wdata;
  assign w_strb = (wstate == W_ADDR) ? ws_q : s_axil_wstrb;
  assign bm     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign w_fire = (wstate == W_IDLE && s_axil_awvalid && s_axil_wvalid) ||
                  (wstate == W_DATA && s_axil_wvalid) ||
                  (wstate == W_ADDR && s_axil_awvalid);

  always_comb begin
    wr_resp = DECERR;
    if (woff == 32'h0 || woff == 32'h4 || woff == 32'h8 || woff == 32'hC)
      wr_resp = OKAY;
    else if (woff == 32'h100 || woff == 32'h104 || woff == 32'h108 ||
             (woff >= 32'h200 && woff < MPQ_END) || (woff >= 32'h1000 && woff < STD_END))
      wr_resp = SLVERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate         <= W_IDLE;
      s_axil_awready <= 1'b1;
      s_axil_wready  <= 1'b1;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= OKAY;
      aw_q           <= '0;
      wd_q           <= '0;
      ws_q           <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (s_axil_awvalid) aw_q <= s_axil_awaddr;
          if (s_axil_wvalid) begin wd_q <= s_axil_wdata; ws_q <= s_axil_wstrb; end
          if (s_axil_awvalid && s_axil_wvalid) begin
            wstate <= W_RESP; s_axil_awready <= 1'b0; s_axil_wready <= 1'b0;
          end else if (s_axil_awvalid) begin
            wstate <= W_DATA; s_axil_awready <= 1'b0;
          end else if (s_axil_wvalid) begin
            wstate <= W_ADDR; s_axil_wready <= 1'b0;
          end
        end
        W_DATA: if (s_axil_wvalid)  begin wstate <= W_RESP; s_axil_wready  <= 1'b0; end
        W_ADDR: if (s_axil_awvalid) begin wstate <= W_RESP; s_axil_awready <= 1'b0; end
        W_RESP: if (s_axil_bready) begin
          wstate <= W_IDLE; s_axil_awready <= 1'b1; s_axil_wready <= 1'b1; s_axil_bvalid <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase
      if (w_fire) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
      end
    end
  end

  // ---------------- registers ----------------
  logic [NUM_CLUSTERS-1:0] wmask, wbits, eoc_clr, eoc_set;
  assign wmask   = bm[NUM_CLUSTERS-1:0];
  assign wbits   = w_data[NUM_CLUSTERS-1:0];
  assign eoc_clr = (w_fire && woff == 32'h8) ? (wbits & wmask) : '0;
  assign eoc_set = eoc_q & ~eoc_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_en   <= '0;
      aux_rst    <= 1'b1;
      eoc_sticky <= '0;
      irq_mask   <= '0;
      eoc_q      <= '0;
      eoc_prev   <= '0;
      busy_q     <= '0;
      mpq_q      <= '0;
      irq_o      <= 1'b0;
    end else begin
      eoc_q    <= cl_eoc_i;
      eoc_prev <= eoc_q;
      busy_q   <= cl_busy_i;
      mpq_q    <= mpq_full_i;
      // set after clear so a coincident rise keeps the bit
      eoc_sticky <= (eoc_sticky & ~eoc_clr) | eoc_set;
      irq_o      <= |(eoc_sticky & irq_mask);
      if (w_fire && woff == 32'h0) fetch_en <= (fetch_en & ~wmask) | (wbits & wmask);
      if (w_fire && woff == 32'hC) irq_mask <= (irq_mask & ~wmask) | (wbits & wmask);
      if (w_fire && woff == 32'h4 && w_strb[0]) aux_rst <= w_data[0];
    end
  end

  assign cl_fetch_en_o = fetch_en;
  assign aux_rst_o     = aux_rst;

  logic unused;
  assign unused = ^{s_axil_awprot, s_axil_arprot, w_data, bm};
endmodule

// File: tb/tb_pspin_ctrl_csr.sv
// Directed bench for pspin_ctrl_csr: reset state, strobed writes, stdout pops,
// EOC interrupt flow, AXI handshake ordering and address decode.
module tb_pspin_ctrl_csr;
  logic         clk = 1'b0, rst = 1'b1;
  logic [15:0]  awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic         arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [1:0]   fetch_en, eoc = '0, busy = '0;
  logic         aux_rst, irq;
  logic [255:0] mpq_full = '0;
  logic [1:0]   rd_en, dvalid = '0;
  logic [63:0]  dout = '0;

  int checks = 0, failures = 0, pops0 = 0, pops1 = 0;
  logic [31:0] d;
  logic [1:0]  r;

  pspin_ctrl_csr #(.ADDR_WIDTH(16), .NUM_CLUSTERS(2), .NUM_MPQ(256), .NUM_STDOUT(2)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .cl_fetch_en_o(fetch_en), .aux_rst_o(aux_rst), .irq_o(irq),
    .cl_eoc_i(eoc), .cl_busy_i(busy), .mpq_full_i(mpq_full),
    .stdout_rd_en(rd_en), .stdout_dout(dout), .stdout_data_valid(dvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_en[0]) pops0++;
    if (rd_en[1]) pops1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk); araddr = a; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_seen", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp; rready = 1;
    @(negedge clk); rready = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] v, input logic [3:0] s,
                    output logic [1:0] resp);
    int n;
    @(negedge clk); awaddr = a; awvalid = 1; wdata = v; wstrb = s; wvalid = 1; bready = 0;
    @(negedge clk); awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_seen", 32'(bvalid), 32'd1);
    resp = bresp; bready = 1;
    @(negedge clk); bready = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_aux_rst_o", 32'(aux_rst), 1);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_fetch_en", 32'(fetch_en), 0);
    rd(16'h0004, d, r); chk("rd_aux", d, 32'h1); chk("rd_aux_resp", 32'(r), 0);
    rd(16'h0000, d, r); chk("rd_fetch", d, 32'h0); chk("rd_fetch_resp", 32'(r), 0);

    // strobed writes
    wr(16'h0000, 32'hFFFF_FFFF, 4'h1, r);
    chk("wr_fetch_resp", 32'(r), 0); chk("fetch_en_11", 32'(fetch_en), 32'h3);
    wr(16'h0000, 32'h0, 4'h2, r);
    chk("fetch_en_strb_off", 32'(fetch_en), 32'h3);

    // EOC capture and RO write
    @(negedge clk); eoc = 2'b10; busy = 2'b01;
    repeat (3) @(negedge clk);
    rd(16'h0100, d, r); chk("rd_eoc", d, 32'h2);
    rd(16'h0104, d, r); chk("rd_busy", d, 32'h1);
    rd(16'h0008, d, r); chk("sticky_from_eoc1", d, 32'h2);
    wr(16'h0100, 32'h3, 4'hF, r); chk("wr_ro_slverr", 32'(r), 2);
    rd(16'h0100, d, r); chk("eoc_unchanged", d, 32'h2);

    // stdout
    @(negedge clk); dvalid = 2'b11; dout = {32'hDEAD_BEEF, 32'h1111_1111};
    rd(16'h0108, d, r); chk("stdout_status", d, 32'h3);
    rd(16'h1004, d, r); chk("pop1_data", d, 32'hDEAD_BEEF); chk("pop1_resp", 32'(r), 0);
    chk("pop1_pulses", 32'(pops1), 1); chk("pop0_none", 32'(pops0), 0);
    rd(16'h1000, d, r); chk("pop0_data", d, 32'h1111_1111); chk("pop0_pulses", 32'(pops0), 1);
    @(negedge clk); dvalid = 2'b00;
    rd(16'h1004, d, r); chk("empty_data", d, 32'hFFFF_FFFF); chk("empty_resp", 32'(r), 0);
    chk("empty_no_pop", 32'(pops1), 1);

    // sticky clear with strobes, then interrupt
    wr(16'h0008, 32'h2, 4'h2, r); rd(16'h0008, d, r); chk("w1c_strb_off", d, 32'h2);
    wr(16'h0008, 32'hFFFF_FFFF, 4'h1, r); chk("w1c_resp", 32'(r), 0);
    rd(16'h0008, d, r); chk("w1c_cleared", d, 32'h0);
    wr(16'h000C, 32'h1, 4'hF, r); rd(16'h000C, d, r); chk("irq_mask", d, 32'h1);
    chk("irq_idle", 32'(irq), 0);
    @(negedge clk); eoc = 2'b11;
    repeat (3) @(negedge clk);
    chk("irq_set", 32'(irq), 1);
    rd(16'h0008, d, r); chk("sticky0_set", d, 32'h1);
    wr(16'h0008, 32'h1, 4'hF, r); chk("irq_cleared", 32'(irq), 0);
    rd(16'h0008, d, r); chk("sticky0_clr", d, 32'h0);
    @(negedge clk); eoc = 2'b10;
    repeat (3) @(negedge clk);
    @(negedge clk); eoc = 2'b11;
    wr(16'h0008, 32'h1, 4'hF, r);
    rd(16'h0008, d, r); chk("set_beats_clear", d, 32'h1);
    chk("irq_after_race", 32'(irq), 1);

    // W three cycles ahead of AW, then stalled B
    @(negedge clk); wdata = 32'h0; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); wvalid = 0;
    chk("waddr_wready", 32'(wready), 0); chk("waddr_awready", 32'(awready), 1);
    @(negedge clk);
    @(negedge clk); awaddr = 16'h000C; awvalid = 1;
    chk("pre_aw_bvalid", 32'(bvalid), 0);
    @(negedge clk); awvalid = 0;
    chk("bvalid_after_aw", 32'(bvalid), 1); chk("bresp_mask", 32'(bresp), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 1); chk("awready_hold", 32'(awready), 0);
    end
    bready = 1;
    @(negedge clk); bready = 0;
    chk("bvalid_done", 32'(bvalid), 0); chk("awready_back", 32'(awready), 1);
    chk("irq_masked", 32'(irq), 0);

    // MPQ and decode
    @(negedge clk); mpq_full = '0; mpq_full[255] = 1'b1; mpq_full[32] = 1'b1;
    repeat (2) @(negedge clk);
    rd(16'h021C, d, r); chk("mpq7", d, 32'h8000_0000); chk("mpq7_resp", 32'(r), 0);
    rd(16'h0204, d, r); chk("mpq1", d, 32'h1);
    rd(16'h0220, d, r); chk("unmapped_data", d, 32'hFFFF_FFFF); chk("unmapped_resp", 32'(r), 3);
    rd(16'h1008, d, r); chk("stdout2_decerr", 32'(r), 3);
    wr(16'h021C, 32'h0, 4'hF, r); chk("wr_mpq_slverr", 32'(r), 2);
    wr(16'h0220, 32'h0, 4'hF, r); chk("wr_unmapped_decerr", 32'(r), 3);
    rd(16'h0006, d, r); chk("low_bits_ignored", d, 32'h1);
    wr(16'h0004, 32'h0, 4'h1, r); chk("aux_rst_low", 32'(aux_rst), 0);

    // simultaneous read and write of FETCH_EN
    @(negedge clk); araddr = 16'h0; arvalid = 1; awaddr = 16'h0; awvalid = 1;
    wdata = 32'h1; wstrb = 4'h1; wvalid = 1;
    @(negedge clk); arvalid = 0; awvalid = 0; wvalid = 0;
    chk("simul_rvalid", 32'(rvalid), 1); chk("simul_old_value", rdata, 32'h3);
    chk("simul_bvalid", 32'(bvalid), 1); chk("simul_new_fetch", 32'(fetch_en), 32'h1);
    rready = 1; bready = 1;
    @(negedge clk); rready = 0; bready = 0;

    // reset during a half-done write
    @(negedge clk); awaddr = 16'h0; awvalid = 1;
    @(negedge clk); awvalid = 0;
    chk("half_awready", 32'(awready), 0);
    rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("mid_rst_awready", 32'(awready), 1); chk("mid_rst_wready", 32'(wready), 1);
    chk("mid_rst_fetch", 32'(fetch_en), 0); chk("mid_rst_aux", 32'(aux_rst), 1);
    chk("mid_rst_bvalid", 32'(bvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
